// File: rtl/onehot_req_gen.sv
// Debounced 8-line request collector. Presents one pending request at a time as a
// one-hot code with valid/ack handshake, highest index first.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | nothing presented; i=0, valid=0; picks the top pending bit
// S_PRESENT | i holds a one-hot code, valid=1; waits for ack
module onehot_req_gen #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] raw,
  input  logic       ack,
  output logic [7:0] i,
  output logic       valid,
  output logic       overflow
);

  localparam logic [7:0] DEB_TC = 8'(DEB_CYCLES);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  logic [7:0] r_sync1;
  logic [7:0] r_sync2;
  logic [7:0] r_stable;
  logic [7:0] r_cnt [8];
  logic [7:0] r_pending;
  logic [7:0] r_i;
  logic       r_valid;
  logic       r_overflow;
  state_t     r_state;

  state_t     w_state_next;
  logic [7:0] w_toggle;
  logic [7:0] w_rise;
  logic [7:0] w_sel;
  logic [7:0] w_clr;
  logic [7:0] w_i_next;
  logic       w_valid_next;
  logic [7:0] w_pending_next;
  logic       w_lost;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  // A line flips on the edge where its mismatch count would reach the terminal value.
  always_comb begin
    w_toggle = '0;
    for (int n = 0; n < 8; n++) begin
      w_toggle[n] = (r_sync2[n] != r_stable[n]) && ((r_cnt[n] + 8'd1) == DEB_TC);
    end
  end

  assign w_rise = w_toggle & ~r_stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= '0;
      for (int n = 0; n < 8; n++) begin
        r_cnt[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 8; n++) begin
        if (r_sync2[n] == r_stable[n]) begin
          r_cnt[n] <= '0;
        end else if (w_toggle[n]) begin
          r_stable[n] <= ~r_stable[n];
          r_cnt[n]    <= '0;
        end else begin
          r_cnt[n] <= r_cnt[n] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int n = 0; n < 8; n++) begin
      if (r_pending[n]) begin
        w_sel    = '0;
        w_sel[n] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_i_next     = r_i;
    w_valid_next = r_valid;
    w_clr        = '0;
    case (r_state)
      S_IDLE: begin
        if (|r_pending) begin
          w_i_next     = w_sel;
          w_valid_next = 1'b1;
          w_clr        = w_sel;
          w_state_next = S_PRESENT;
        end else begin
          w_i_next     = '0;
          w_valid_next = 1'b0;
        end
      end
      S_PRESENT: begin
        if (ack) begin
          w_i_next     = '0;
          w_valid_next = 1'b0;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_i_next     = '0;
        w_valid_next = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_i     <= w_i_next;
      r_valid <= w_valid_next;
    end
  end

  // A rise landing on the same edge its bit is taken for presentation re-arms it, not lost.
  assign w_pending_next = (r_pending & ~w_clr) | w_rise;
  assign w_lost         = |(w_rise & r_pending & ~w_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      if (w_lost) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign i        = r_i;
  assign valid    = r_valid;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_onehot_req_gen.sv
// Directed bench for onehot_req_gen with DEB_CYCLES=4: latency, glitch rejection,
// priority ordering, overflow and reset behaviour.
module tb_onehot_req_gen;

  logic       clk;
  logic       rst;
  logic [7:0] raw;
  logic       ack;
  logic [7:0] i;
  logic       valid;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  onehot_req_gen #(.DEB_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .raw      (raw),
    .ack      (ack),
    .i        (i),
    .valid    (valid),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    for (int c = 0; c < 30 && valid !== 1'b1; c++) tick();
    chk(tag, {7'd0, valid}, 8'h01);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    raw = 8'h00;
    ack = 1'b0;
    tick(2);
    chk("rst_i", i, 8'h00);
    chk("rst_valid", {7'd0, valid}, 8'h00);
    chk("rst_ovf", {7'd0, overflow}, 8'h00);

    // Exact latency: raw[3] set before edge 0, pending at edge 5, valid at edge 6.
    rst = 1'b0;
    tick();
    raw = 8'h08;
    tick(6);
    chk("lat_valid_e5", {7'd0, valid}, 8'h00);
    tick();
    chk("lat_valid_e6", {7'd0, valid}, 8'h01);
    chk("lat_i_e6", i, 8'h08);
    tick(3);
    chk("hold_i", i, 8'h08);
    chk("hold_valid", {7'd0, valid}, 8'h01);
    ack_pulse();
    chk("ack_i", i, 8'h00);
    chk("ack_valid", {7'd0, valid}, 8'h00);
    raw = 8'h00;
    tick(10);
    chk("fall_no_req", {7'd0, valid}, 8'h00);

    // Three-cycle glitch on raw[2] never reaches the debounced level.
    raw = 8'h04;
    tick(3);
    raw = 8'h00;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("glitch_valid", {7'd0, valid}, 8'h00);
      chk("glitch_i", i, 8'h00);
    end

    // Simultaneous bits 7 and 0: 0x80 first, one IDLE cycle, then 0x01.
    raw = 8'h81;
    wait_valid("pri_wait");
    chk("pri_first", i, 8'h80);
    ack_pulse();
    chk("pri_gap_valid", {7'd0, valid}, 8'h00);
    chk("pri_gap_i", i, 8'h00);
    tick();
    chk("pri_second", i, 8'h01);
    chk("pri_second_v", {7'd0, valid}, 8'h01);
    ack_pulse();
    chk("pri_ovf", {7'd0, overflow}, 8'h00);
    raw = 8'h00;
    tick(10);

    // Bit 5 pressed twice with the first press already accepted: no overflow.
    raw = 8'h20;
    wait_valid("b5a_wait");
    chk("b5a_i", i, 8'h20);
    ack_pulse();
    raw = 8'h00;
    tick(10);
    raw = 8'h20;
    wait_valid("b5b_wait");
    chk("b5b_i", i, 8'h20);
    ack_pulse();
    chk("b5b_ovf", {7'd0, overflow}, 8'h00);
    raw = 8'h00;
    tick(10);

    // Bit 5 pressed twice while blocked behind bit 7: second rise is lost.
    raw = 8'h80;
    wait_valid("ovf_wait7");
    chk("ovf_i7", i, 8'h80);
    raw = 8'hA0;
    tick(10);
    chk("ovf_hold_i", i, 8'h80);
    chk("ovf_before", {7'd0, overflow}, 8'h00);
    raw = 8'h80;
    tick(10);
    raw = 8'hA0;
    tick(10);
    chk("ovf_set", {7'd0, overflow}, 8'h01);
    ack_pulse();
    chk("ovf_gap", {7'd0, valid}, 8'h00);
    tick();
    chk("ovf_i5", i, 8'h20);
    ack_pulse();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("ovf_single", i, 8'h00);
    end
    chk("ovf_sticky", {7'd0, overflow}, 8'h01);
    raw = 8'h00;
    tick(10);

    // Reset during presentation; raw[4] held re-presents DEB_CYCLES+3 edges later.
    raw = 8'h10;
    wait_valid("rst_wait");
    chk("rst_pre_i", i, 8'h10);
    rst = 1'b1;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("rstp_i", i, 8'h00);
    chk("rstp_valid", {7'd0, valid}, 8'h00);
    chk("rstp_ovf", {7'd0, overflow}, 8'h00);
    rst = 1'b0;
    tick(6);
    chk("rel_e6_valid", {7'd0, valid}, 8'h00);
    tick();
    chk("rel_e7_valid", {7'd0, valid}, 8'h01);
    chk("rel_e7_i", i, 8'h10);
    ack_pulse();
    raw = 8'h00;
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/onehot_req_gen.md
ONEHOT_REQ_GEN -- requirements
Module: onehot_req_gen

Interface
REQ-001 Parameter: DEB_CYCLES, default 4, consecutive stable cycles required to accept a level change on any input line; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 raw  input  8  asynchronous switch/key lines, bit n = request source n.
REQ-005 ack  input  1  downstream consumer has taken the presented code.
REQ-006 i  output  8  one-hot request vector for the downstream 8-to-3 encoder; all-zero when nothing is presented.
REQ-007 valid  output  1  high while i carries a presented request.
REQ-008 overflow  output  1  sticky flag: a request event was lost.

Function
REQ-009 Each raw bit SHALL pass through a 2-flop synchronizer; sync output = sync2[n].
REQ-010 Per bit: debounced level stable[n] and an 8-bit counter cnt[n]; cnt[n] clears on any cycle where sync2[n]==stable[n].
REQ-011 While sync2[n]!=stable[n], cnt[n] increments each edge; on the edge where it would reach DEB_CYCLES, stable[n] toggles and cnt[n] clears.
REQ-012 A mismatch interrupted by even one matching cycle SHALL restart counting from 0 (glitch rejection).
REQ-013 A 0->1 toggle of stable[n] SHALL set pending[n] on that same edge; 1->0 toggles set nothing.
REQ-014 If pending[n] is already 1 when a new rising event on bit n occurs, overflow SHALL set and stay set until rst.
REQ-015 If a rising event on bit n coincides with the edge that clears pending[n] for presentation, pending[n] SHALL remain 1 and overflow SHALL NOT set.
REQ-016 Presentation FSM states: IDLE, PRESENT.
REQ-017 IDLE: if pending!=0, on the next edge load i with the highest-index pending bit (bit 7 highest priority), clear that pending bit, set valid=1, go PRESENT; else hold i=0, valid=0.
REQ-018 PRESENT: hold i and valid unchanged regardless of pending changes; when ack=1, on that edge set i=0, valid=0, go IDLE.
REQ-019 ack while in IDLE SHALL be ignored; minimum spacing between two presented codes is 2 cycles (one IDLE cycle always separates them).
REQ-020 i SHALL at all times be either all-zero or exactly one-hot; valid==1 iff i!=0.
REQ-021 Latency: raw[n] rising and held from before edge k, pending[n] sets at edge k+1+DEB_CYCLES; if FSM is IDLE, valid rises at edge k+2+DEB_CYCLES.
REQ-022 Multiple pending bits SHALL be presented one per handshake in descending index order, lower bits waiting (no loss unless REQ-014 applies).

Reset
REQ-023 rst=1 at an edge SHALL clear sync flops, stable, cnt, pending, i=8'h00, valid=0, overflow=0, state=IDLE, overriding all other activity including a pending handshake.
REQ-024 raw held high through reset SHALL be treated as a new rising event after release (stable restarts from 0).
REQ-025 Outputs SHALL be deterministic from the first edge with rst=1; no reliance on initial values.

Verification
REQ-026 DEB_CYCLES=4, raw=8'h08 from before edge 0, ack=0 -> pending[3] at edge 5, valid=1 with i=8'h08 at edge 6, held until ack.
REQ-027 raw[2] pulsed high 3 cycles then low (DEB_CYCLES=4) -> stable never toggles; valid stays 0, i stays 8'h00.
REQ-028 raw=8'h81 rising together, ack pulsed one cycle whenever valid=1 -> i=8'h80 presented first, then i=8'h01 after one IDLE cycle; overflow=0.
REQ-029 raw[5] pressed, released (debounced), pressed again before ack -> second rising event with pending[5]=0 after presentation accepted; with presentation blocked by a higher pending bit, overflow=1 and only one 8'h20 presented.
REQ-030 rst asserted while valid=1, i=8'h10 -> next edge i=8'h00, valid=0, overflow=0; raw[4] still high -> re-presented after DEB_CYCLES+3 edges from reset release.
